// File: rtl/ysyx_201979054_axi4_pkg.sv
// Shared types and response codes for the ysyx_201979054 AXI4 slave memory.
package ysyx_201979054_axi4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_W_DATA = 2'd1,
        ST_B_RESP = 2'd2,
        ST_R_DATA = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_201979054_axi4_mem_array.sv
// Byte-strobed 64-bit word array: synchronous write, asynchronous read, no reset.
module ysyx_201979054_axi4_mem_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [63:0]              i_wdata,
    input  logic [7:0]               i_wstrb,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [63:0]              o_rdata
);

    logic [63:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i_wstrb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_201979054_axi4_slave_mem.sv
// Single-transaction AXI4 INCR-burst slave memory of MEM_DEPTH 64-bit words.
// Define AXI_SLAVE_BACKPRESSURE_EN to insert one wait state per W/R beat.
module ysyx_201979054_axi4_slave_mem
    import ysyx_201979054_axi4_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [1:0]  rresp,
    output logic [63:0] rdata,
    output logic        rlast
);

    localparam int unsigned AW    = $clog2(MEM_DEPTH);
    localparam logic [28:0] LIMIT = 29'(MEM_DEPTH);

    state_t      r_state, w_next;
    logic [3:0]  r_id;
    logic [28:0] r_idx;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_slverr;
    logic        r_decerr;

    logic        w_inrange;
    logic        w_len_hit;
    logic        w_wbeat;
    logic        w_rbeat;
    logic        w_stall;
    logic [63:0] w_mem_rdata;
    logic        w_unused;

    assign w_inrange = (r_idx < LIMIT);
    assign w_len_hit = (r_cnt == r_len);
    assign w_wbeat   = wvalid & wready;
    assign w_rbeat   = rvalid & rready;
    assign w_unused  = ^{awaddr[2:0], araddr[2:0]};

`ifdef AXI_SLAVE_BACKPRESSURE_EN
    logic r_toggle;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_toggle <= 1'b0;
        else      r_toggle <= ~r_toggle;
    end

    assign w_stall = r_toggle;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (awvalid)      w_next = ST_W_DATA;
                else if (arvalid) w_next = ST_R_DATA;
            end
            ST_W_DATA: if (w_wbeat && wlast) w_next = ST_B_RESP;
            ST_B_RESP: if (bready)           w_next = ST_IDLE;
            ST_R_DATA: if (w_rbeat && rlast) w_next = ST_IDLE;
            default:                         w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = RESP_OKAY;
        rvalid  = 1'b0;
        rid     = '0;
        rresp   = RESP_OKAY;
        rdata   = '0;
        rlast   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                awready = awvalid;
                arready = arvalid & ~awvalid;
            end
            ST_W_DATA: wready = ~w_stall;
            ST_B_RESP: begin
                bvalid = 1'b1;
                bid    = r_id;
                // Address decode errors outrank burst-length mismatches.
                bresp  = r_decerr ? RESP_DECERR : (r_slverr ? RESP_SLVERR : RESP_OKAY);
            end
            ST_R_DATA: begin
                rvalid = ~w_stall;
                rid    = r_id;
                rresp  = w_inrange ? RESP_OKAY : RESP_DECERR;
                rdata  = w_inrange ? w_mem_rdata : '0;
                rlast  = w_len_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_id     <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_slverr <= 1'b0;
            r_decerr <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt    <= '0;
                    r_slverr <= 1'b0;
                    r_decerr <= 1'b0;
                    if (awvalid) begin
                        r_id  <= awid;
                        r_idx <= awaddr[31:3];
                        r_len <= awlen;
                    end else if (arvalid) begin
                        r_id  <= arid;
                        r_idx <= araddr[31:3];
                        r_len <= arlen;
                    end
                end
                ST_W_DATA: begin
                    if (w_wbeat) begin
                        r_idx <= r_idx + 29'd1;
                        r_cnt <= r_cnt + 8'd1;
                        if (!w_inrange)          r_decerr <= 1'b1;
                        if (wlast != w_len_hit)  r_slverr <= 1'b1;
                    end
                end
                ST_R_DATA: begin
                    if (w_rbeat && !rlast) begin
                        r_idx <= r_idx + 29'd1;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    ysyx_201979054_axi4_mem_array #(
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wbeat & w_inrange),
        .i_waddr (r_idx[AW-1:0]),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_raddr (r_idx[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

endmodule
